// File: rtl/test_pattern_gen.sv
// Self-running bring-up pattern source: forced-low start delay, then PATTERN looped MSB first, DIV clocks per bit.
// Optional PWM dimming of '1' bits is enabled by defining TEST_PWM_EN.
module test_pattern_gen #(
    parameter int              DIV        = 4,
    parameter int              LEN        = 8,
    parameter logic [LEN-1:0]  PATTERN    = 8'b1011_0010,
    parameter int              START_DLY  = 2,
    parameter int              PWM_PERIOD = 4,
    parameter int              PWM_DUTY   = 3
) (
    input  logic clk,
    input  logic rst,
    output logic out
);

    typedef enum logic {
        WAIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int DLY_W   = (START_DLY > 1) ? $clog2(START_DLY) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(LEN - 1);
    localparam logic [DLY_W-1:0]   DLY_LAST   = DLY_W'((START_DLY > 0) ? START_DLY - 1 : 0);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cur_bit_q, cur_bit_d;
    logic               out_d;
    logic               tick;

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        state_d   = state_q;
        dly_d     = dly_q;
        idx_d     = idx_q;
        cur_bit_d = cur_bit_q;
        case (state_q)
            WAIT: begin
                cur_bit_d = 1'b0;
                if (START_DLY == 0) begin
                    // No delay: leave WAIT on the first edge out of reset, tick or not.
                    state_d   = RUN;
                    idx_d     = '0;
                    cur_bit_d = PATTERN[LEN-1];
                end else if (tick) begin
                    if (dly_q == DLY_LAST) begin
                        state_d   = RUN;
                        idx_d     = '0;
                        cur_bit_d = PATTERN[LEN-1];
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (tick) begin
                    idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    cur_bit_d = PATTERN[IDX_LAST - idx_d];
                end
            end
            default: state_d = WAIT;
        endcase
    end

`ifdef TEST_PWM_EN
    localparam int PWM_W = $clog2(PWM_PERIOD + 1);
    localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_PERIOD - 1);
    localparam logic [PWM_W-1:0] DUTY_V   = PWM_W'(PWM_DUTY);

    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

    assign pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
    // Output register sees next-state values so the PWM gate stays aligned with bit edges.
    assign out_d     = cur_bit_d & (pwm_cnt_d < DUTY_V);

    always_ff @(posedge clk) begin
        if (rst) pwm_cnt_q <= '0;
        else     pwm_cnt_q <= pwm_cnt_d;
    end
`else
    assign out_d = cur_bit_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT;
            presc_q   <= '0;
            dly_q     <= '0;
            idx_q     <= '0;
            cur_bit_q <= 1'b0;
            out       <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            dly_q     <= dly_d;
            idx_q     <= idx_d;
            cur_bit_q <= cur_bit_d;
            out       <= out_d;
        end
    end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen: default instance plus a DIV=1/LEN=4/START_DLY=0 instance.
// Expected outputs are derived from edge numbers after reset release.
module tb_test_pattern_gen;

    localparam logic [7:0] PAT_D = 8'b1011_0010;
    localparam logic [3:0] PAT_P = 4'b1001;

    logic clk;
    logic rst;
    logic rst_p;
    logic out;
    logic out_p;

    int checks;
    int errors;
    logic [0:0] exp_q[$];

    test_pattern_gen dut (
        .clk (clk),
        .rst (rst),
        .out (out)
    );

    test_pattern_gen #(
        .DIV       (1),
        .LEN       (4),
        .PATTERN   (4'b1001),
        .START_DLY (0)
    ) dut_p (
        .clk (clk),
        .rst (rst_p),
        .out (out_p)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected default-instance output after edge e (e >= 1) following reset release.
    function automatic logic exp_def(int e);
        logic b;
        if (e < 8) return 1'b0;
        b = PAT_D[7 - (((e - 8) / 4) % 8)];
`ifdef TEST_PWM_EN
        b = b & ((e % 4) < 3);
`endif
        return b;
    endfunction

    function automatic logic exp_par(int e);
        logic b;
        b = PAT_P[3 - ((e - 1) % 4)];
`ifdef TEST_PWM_EN
        b = b & ((e % 4) < 3);
`endif
        return b;
    endfunction

    task automatic check_def(string name, int e);
        logic exp_v;
        exp_v = exp_q.pop_front();
        checks++;
        if (out !== exp_v) begin
            errors++;
            $display("FAIL %s edge %0d out=%b expected=%b", name, e, out, exp_v);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rst_p = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d out=%b expected=0", i, out);
            end
            checks++;
            if (out_p !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_p cycle %0d out_p=%b expected=0", i, out_p);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp_q.push_back(1'b0);
            check_def("start_delay", e);
        end
    endtask

    task automatic test_start();
        for (int e = 8; e <= 39; e++) begin
            step();
            exp_q.push_back(exp_def(e));
            check_def("first_loop", e);
        end
    endtask

    task automatic test_wrap();
        for (int e = 40; e <= 8 + 32 * 4 - 1; e++) begin
            step();
            exp_q.push_back(exp_def(e));
            check_def("wrap", e);
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            step();
            exp_q.push_back(exp_def(e));
            check_def("pre_mid_reset", e);
        end
        rst = 1'b1;
        step();
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_edge20 out=%b expected=0", out);
        end
        rst = 1'b0;
        for (int r = 1; r <= 16; r++) begin
            step();
            exp_q.push_back(exp_def(r));
            check_def("post_mid_reset", r);
        end
    endtask

    task automatic test_params();
        rst_p = 1'b1;
        step();
        step();
        rst_p = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            logic exp_v;
            step();
            exp_v = exp_par(e);
            checks++;
            if (out_p !== exp_v) begin
                errors++;
                $display("FAIL params edge %0d out_p=%b expected=%b", e, out_p, exp_v);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        rst_p  = 1'b1;
        test_reset();
        test_start();
        test_wrap();
        test_mid_reset();
        test_params();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover size=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
